// File: rtl/pc_sequencer_pkg.sv
// Shared fetch-sequencer types and constants: FSM states, NOP encoding, default vectors.
// No logic lives here beyond a small alignment helper.
package pc_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ  = 3'd1,
    ST_WAIT = 3'd2,
    ST_HOLD = 3'd3,
    ST_HALT = 3'd4
  } state_e;

  localparam logic [31:0] NOP_INST         = 32'h0000_0013;
  localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] DEF_TRAP_VECTOR  = 32'h0000_0100;

  function automatic logic is_misaligned(input logic [31:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/pc_sequencer.sv
// PC owner / fetch sequencer: one outstanding imem fetch, 3 cycles per instruction best case,
// all outputs registered; stall holds the presented instruction, imem_gnt=0 holds the request.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = DEF_RESET_VECTOR,
  parameter logic [31:0] TRAP_VECTOR  = DEF_TRAP_VECTOR
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  input  logic        halt_req,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  output logic        flush,
  output logic        misalign_trap,
  output logic        halted
);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pend_pc_q, pend_pc_d;
  logic        pend_q, pend_d;
  logic        kill_q, kill_d;
  logic        halt_q, halt_d;
  logic        imem_req_q, imem_req_d;
  logic        if_valid_q, if_valid_d;
  logic [31:0] if_pc_q, if_pc_d;
  logic [31:0] if_inst_q, if_inst_d;
  logic        flush_q, flush_d;
  logic        trap_q, trap_d;
  logic        halted_q, halted_d;

  logic        redir_act;
  logic        redir_mis;
  logic [31:0] redir_tgt;
  logic [31:0] pc_seq;

  always_comb begin
    redir_act = redirect_valid && (state_q inside {ST_REQ, ST_WAIT, ST_HOLD});
    redir_mis = is_misaligned(redirect_pc);
    redir_tgt = redir_mis ? TRAP_VECTOR : redirect_pc;
    pc_seq    = if_pc_q + 32'd4;
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pend_pc_d  = pend_pc_q;
    pend_d     = pend_q;
    kill_d     = kill_q;
    halt_d     = halt_q | halt_req;
    imem_req_d = imem_req_q;
    if_valid_d = if_valid_q;
    if_pc_d    = if_pc_q;
    if_inst_d  = if_inst_q;
    flush_d    = redir_act;
    trap_d     = redir_act && redir_mis;
    halted_d   = halted_q;

    case (state_q)
      ST_IDLE: begin
        state_d    = ST_REQ;
        imem_req_d = 1'b1;
        pc_d       = RESET_VECTOR;
      end
      ST_REQ: begin
        // Address stays put until granted; a redirect only arms the kill.
        if (redir_act) begin
          pend_d    = 1'b1;
          pend_pc_d = redir_tgt;
        end
        if (imem_gnt) begin
          state_d    = ST_WAIT;
          imem_req_d = 1'b0;
          pend_d     = 1'b0;
          if (redir_act || pend_q) kill_d = 1'b1;
        end
      end
      ST_WAIT: begin
        if (redir_act) begin
          kill_d    = 1'b1;
          pend_pc_d = redir_tgt;
        end
        if (imem_rvalid) begin
          if (kill_q || redir_act) begin
            kill_d = 1'b0;
            if (halt_d) begin
              state_d  = ST_HALT;
              halted_d = 1'b1;
            end else begin
              state_d    = ST_REQ;
              imem_req_d = 1'b1;
              pc_d       = redir_act ? redir_tgt : pend_pc_q;
            end
          end else begin
            state_d    = ST_HOLD;
            if_valid_d = 1'b1;
            if_pc_d    = pc_q;
            if_inst_d  = imem_rdata;
          end
        end
      end
      ST_HOLD: begin
        if (redir_act) begin
          state_d    = ST_REQ;
          if_valid_d = 1'b0;
          imem_req_d = 1'b1;
          pc_d       = redir_tgt;
        end else if (!stall) begin
          if_valid_d = 1'b0;
          pc_d       = pc_seq;
          if (halt_d) begin
            state_d  = ST_HALT;
            halted_d = 1'b1;
          end else begin
            state_d    = ST_REQ;
            imem_req_d = 1'b1;
          end
        end
      end
      ST_HALT: begin
        imem_req_d = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      pc_q       <= RESET_VECTOR;
      pend_pc_q  <= RESET_VECTOR;
      pend_q     <= 1'b0;
      kill_q     <= 1'b0;
      halt_q     <= 1'b0;
      imem_req_q <= 1'b0;
      if_valid_q <= 1'b0;
      if_pc_q    <= 32'h0;
      if_inst_q  <= NOP_INST;
      flush_q    <= 1'b0;
      trap_q     <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pend_pc_q  <= pend_pc_d;
      pend_q     <= pend_d;
      kill_q     <= kill_d;
      halt_q     <= halt_d;
      imem_req_q <= imem_req_d;
      if_valid_q <= if_valid_d;
      if_pc_q    <= if_pc_d;
      if_inst_q  <= if_inst_d;
      flush_q    <= flush_d;
      trap_q     <= trap_d;
      halted_q   <= halted_d;
    end
  end

  assign imem_req      = imem_req_q;
  assign imem_addr     = pc_q;
  assign if_valid      = if_valid_q;
  assign if_pc         = if_pc_q;
  assign if_inst       = if_inst_q;
  assign flush         = flush_q;
  assign misalign_trap = trap_q;
  assign halted        = halted_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed cycle tables, a mid-HALT reset sequence, and a randomized
// run checked against a program-order model with a bench-side memory responder.
module tb_pc_sequencer;

  localparam logic [31:0] TRAP = 32'h0000_0100;
  localparam logic [31:0] NOP  = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        stall = 1'b0;
  logic        halt_req = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        flush;
  logic        misalign_trap;
  logic        halted;

  int n_tests = 0;
  int n_fail  = 0;

  pc_sequencer dut (
    .clk(clk), .rst_n(rst_n),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .stall(stall), .halt_req(halt_req),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .if_valid(if_valid), .if_pc(if_pc), .if_inst(if_inst),
    .flush(flush), .misalign_trap(misalign_trap), .halted(halted)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        gnt, rv;
    logic [31:0] rdata;
    logic        stl, hlt, rdv;
    logic [31:0] rdpc;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_ifv;
    logic [31:0] e_ifpc;
    logic        e_flush, e_trap, e_halt;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [31:0] mem(input logic [31:0] a);
    return {a[15:0] ^ 16'hA5C3, a[31:16] ^ ~a[15:0]};
  endfunction

  function automatic vec_t v(input logic gnt, input logic rv, input logic [31:0] rdata,
                             input logic stl, input logic hlt, input logic rdv, input logic [31:0] rdpc,
                             input logic e_req, input logic [31:0] e_addr, input logic e_ifv,
                             input logic [31:0] e_ifpc, input logic e_flush, input logic e_trap,
                             input logic e_halt);
    vec_t r;
    r.gnt = gnt; r.rv = rv; r.rdata = rdata; r.stl = stl; r.hlt = hlt; r.rdv = rdv; r.rdpc = rdpc;
    r.e_req = e_req; r.e_addr = e_addr; r.e_ifv = e_ifv; r.e_ifpc = e_ifpc;
    r.e_flush = e_flush; r.e_trap = e_trap; r.e_halt = e_halt;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic drive_idle();
    redirect_valid = 1'b0; redirect_pc = 32'h0; stall = 1'b0; halt_req = 1'b0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
  endtask

  // Leaves the bench at the negedge where reset releases: the DUT is in its first (idle) cycle.
  task automatic do_reset();
    @(negedge clk);
    drive_idle();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run_table(input string tag);
    for (int i = 0; i < tbl.size(); i++) begin
      chk($sformatf("%s[%0d].req", tag, i), {31'b0, imem_req}, {31'b0, tbl[i].e_req});
      if (tbl[i].e_req) chk($sformatf("%s[%0d].addr", tag, i), imem_addr, tbl[i].e_addr);
      chk($sformatf("%s[%0d].ifv", tag, i), {31'b0, if_valid}, {31'b0, tbl[i].e_ifv});
      if (tbl[i].e_ifv) begin
        chk($sformatf("%s[%0d].ifpc", tag, i), if_pc, tbl[i].e_ifpc);
        chk($sformatf("%s[%0d].inst", tag, i), if_inst, mem(tbl[i].e_ifpc));
      end
      chk($sformatf("%s[%0d].flush", tag, i), {31'b0, flush}, {31'b0, tbl[i].e_flush});
      chk($sformatf("%s[%0d].trap", tag, i), {31'b0, misalign_trap}, {31'b0, tbl[i].e_trap});
      chk($sformatf("%s[%0d].halted", tag, i), {31'b0, halted}, {31'b0, tbl[i].e_halt});
      imem_gnt = tbl[i].gnt; imem_rvalid = tbl[i].rv; imem_rdata = tbl[i].rdata;
      stall = tbl[i].stl; halt_req = tbl[i].hlt;
      redirect_valid = tbl[i].rdv; redirect_pc = tbl[i].rdpc;
      @(negedge clk);
    end
    drive_idle();
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".req"},    {31'b0, imem_req}, 32'd0);
    chk({tag, ".addr"},   imem_addr, 32'h0);
    chk({tag, ".ifv"},    {31'b0, if_valid}, 32'd0);
    chk({tag, ".ifpc"},   if_pc, 32'h0);
    chk({tag, ".inst"},   if_inst, NOP);
    chk({tag, ".flush"},  {31'b0, flush}, 32'd0);
    chk({tag, ".trap"},   {31'b0, misalign_trap}, 32'd0);
    chk({tag, ".halted"}, {31'b0, halted}, 32'd0);
  endtask

  task automatic run_random(input int ncyc);
    logic [31:0] exp_pc, o_addr, p_addr, p_ifpc, p_inst;
    logic        outst, e_flush, e_trap, p_req, p_gnt, p_ifv, p_cons, p_redir;
    int          npres, last_pres, max_gap;
    exp_pc = 32'h0; o_addr = 32'h0; p_addr = 32'h0; p_ifpc = 32'h0; p_inst = 32'h0;
    outst = 1'b0; e_flush = 1'b0; e_trap = 1'b0; p_req = 1'b0; p_gnt = 1'b0;
    p_ifv = 1'b0; p_cons = 1'b0; p_redir = 1'b0;
    npres = 0; last_pres = 0; max_gap = 0;
    for (int k = 0; k < ncyc; k++) begin
      chk("rnd.flush", {31'b0, flush}, {31'b0, e_flush});
      chk("rnd.trap", {31'b0, misalign_trap}, {31'b0, e_trap});
      if (imem_req) chk("rnd.align", {30'b0, imem_addr[1:0]}, 32'd0);
      if (p_req && !p_gnt) begin
        chk("rnd.req_hold", {31'b0, imem_req}, 32'd1);
        chk("rnd.addr_hold", imem_addr, p_addr);
      end
      if (outst) chk("rnd.one_outstanding", {31'b0, imem_req}, 32'd0);
      if (p_ifv) begin
        if (p_cons || p_redir) chk("rnd.ifv_drop", {31'b0, if_valid}, 32'd0);
        else begin
          chk("rnd.ifv_keep", {31'b0, if_valid}, 32'd1);
          chk("rnd.ifpc_stable", if_pc, p_ifpc);
          chk("rnd.inst_stable", if_inst, p_inst);
        end
      end else if (if_valid) begin
        chk("rnd.ifpc", if_pc, exp_pc);
        chk("rnd.inst", if_inst, mem(if_pc));
        npres++;
        if (k - last_pres > max_gap) max_gap = k - last_pres;
        last_pres = k;
      end

      stall = ($urandom_range(0, 2) == 0);
      redirect_valid = (k >= 3) && ($urandom_range(0, 15) == 0);
      case ($urandom_range(0, 7))
        0:       redirect_pc = ($urandom & 32'h0000_0FFC) | {30'b0, 2'($urandom_range(1, 3))};
        1:       redirect_pc = 32'hFFFF_FFFC;
        default: redirect_pc = 32'($urandom_range(0, 1023)) << 2;
      endcase
      if (outst && ($urandom_range(0, 1) == 1)) begin
        imem_rvalid = 1'b1; imem_rdata = mem(o_addr); outst = 1'b0;
      end else if (!outst && ($urandom_range(0, 7) == 0)) begin
        imem_rvalid = 1'b1; imem_rdata = $urandom;
      end else begin
        imem_rvalid = 1'b0; imem_rdata = $urandom;
      end
      if (imem_req && !outst && ($urandom_range(0, 1) == 1)) begin
        imem_gnt = 1'b1; outst = 1'b1; o_addr = imem_addr;
      end else imem_gnt = 1'b0;

      p_cons  = if_valid && !stall;
      p_redir = redirect_valid;
      if (p_cons) exp_pc = if_pc + 32'd4;
      if (redirect_valid) exp_pc = (redirect_pc[1:0] != 2'b00) ? TRAP : redirect_pc;
      e_flush = redirect_valid;
      e_trap  = redirect_valid && (redirect_pc[1:0] != 2'b00);
      p_req = imem_req; p_gnt = imem_gnt; p_addr = imem_addr;
      p_ifv = if_valid; p_ifpc = if_pc; p_inst = if_inst;
      @(negedge clk);
    end
    drive_idle();
    chk("rnd.progress", {31'b0, npres >= 100}, 32'd1);
    chk("rnd.max_gap_bounded", {31'b0, max_gap < 400}, 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1);
  end

  initial begin
    // Fetch stream, stall hold, WAIT redirect, misaligned HOLD redirect, withheld grant, wrap.
    tbl.push_back(v(0,0,0,           0,0,0,0,            0,0,0,0,                      0,0,0)); // 0 idle
    tbl.push_back(v(1,0,0,           0,0,0,0,            1,32'h0,0,0,                  0,0,0)); // 1
    tbl.push_back(v(0,1,mem(32'h0),  0,0,0,0,            0,0,0,0,                      0,0,0)); // 2
    tbl.push_back(v(0,0,0,           0,0,0,0,            0,0,1,32'h0,                  0,0,0)); // 3
    tbl.push_back(v(1,0,0,           0,0,0,0,            1,32'h4,0,0,                  0,0,0)); // 4
    tbl.push_back(v(0,1,mem(32'h4),  0,0,0,0,            0,0,0,0,                      0,0,0)); // 5
    tbl.push_back(v(0,0,0,           0,0,0,0,            0,0,1,32'h4,                  0,0,0)); // 6
    tbl.push_back(v(1,0,0,           0,0,0,0,            1,32'h8,0,0,                  0,0,0)); // 7
    tbl.push_back(v(0,1,mem(32'h8),  0,0,0,0,            0,0,0,0,                      0,0,0)); // 8
    tbl.push_back(v(0,0,0,           1,0,0,0,            0,0,1,32'h8,                  0,0,0)); // 9 stall
    tbl.push_back(v(0,0,0,           1,0,0,0,            0,0,1,32'h8,                  0,0,0)); // 10
    tbl.push_back(v(0,0,0,           1,0,0,0,            0,0,1,32'h8,                  0,0,0)); // 11
    tbl.push_back(v(0,0,0,           1,0,0,0,            0,0,1,32'h8,                  0,0,0)); // 12
    tbl.push_back(v(0,0,0,           0,0,0,0,            0,0,1,32'h8,                  0,0,0)); // 13
    tbl.push_back(v(1,0,0,           0,0,0,0,            1,32'hC,0,0,                  0,0,0)); // 14
    tbl.push_back(v(0,0,0,           0,0,1,32'h200,      0,0,0,0,                      0,0,0)); // 15 redirect in WAIT
    tbl.push_back(v(0,1,mem(32'hC),  0,0,0,0,            0,0,0,0,                      1,0,0)); // 16 killed data
    tbl.push_back(v(1,0,0,           0,0,0,0,            1,32'h200,0,0,                0,0,0)); // 17
    tbl.push_back(v(0,1,mem(32'h200),0,0,0,0,            0,0,0,0,                      0,0,0)); // 18
    tbl.push_back(v(0,0,0,           0,0,1,32'h202,      0,0,1,32'h200,                0,0,0)); // 19 misaligned
    tbl.push_back(v(0,0,0,           0,0,0,0,            1,TRAP,0,0,                   1,1,0)); // 20
    tbl.push_back(v(0,0,0,           0,0,1,32'h40,       1,TRAP,0,0,                   0,0,0)); // 21 redirect, no gnt
    tbl.push_back(v(0,0,0,           0,0,0,0,            1,TRAP,0,0,                   1,0,0)); // 22
    tbl.push_back(v(0,0,0,           0,0,0,0,            1,TRAP,0,0,                   0,0,0)); // 23
    tbl.push_back(v(0,0,0,           0,0,0,0,            1,TRAP,0,0,                   0,0,0)); // 24
    tbl.push_back(v(1,1,32'h1234_5678,0,0,0,0,           1,TRAP,0,0,                   0,0,0)); // 25 stray rvalid
    tbl.push_back(v(0,1,mem(TRAP),   0,0,0,0,            0,0,0,0,                      0,0,0)); // 26 killed data
    tbl.push_back(v(1,0,0,           0,0,0,0,            1,32'h40,0,0,                 0,0,0)); // 27
    tbl.push_back(v(0,1,mem(32'h40), 0,0,0,0,            0,0,0,0,                      0,0,0)); // 28
    tbl.push_back(v(0,0,0,           0,0,0,0,            0,0,1,32'h40,                 0,0,0)); // 29
    tbl.push_back(v(1,1,32'hDEAD_BEEF,0,0,0,0,           1,32'h44,0,0,                 0,0,0)); // 30
    tbl.push_back(v(0,0,0,           0,0,1,32'hFFFF_FFFC,0,0,0,0,                      0,0,0)); // 31
    tbl.push_back(v(0,1,mem(32'h44), 0,0,0,0,            0,0,0,0,                      1,0,0)); // 32
    tbl.push_back(v(1,0,0,           0,0,0,0,            1,32'hFFFF_FFFC,0,0,          0,0,0)); // 33
    tbl.push_back(v(0,1,mem(32'hFFFF_FFFC),0,0,0,0,      0,0,0,0,                      0,0,0)); // 34
    tbl.push_back(v(0,0,0,           0,0,0,0,            0,0,1,32'hFFFF_FFFC,          0,0,0)); // 35
    tbl.push_back(v(0,0,0,           0,0,0,0,            1,32'h0,0,0,                  0,0,0)); // 36 wrap
    do_reset();
    chk_reset_vals("reset0");
    run_table("seq");

    // halt_req pulsed in WAIT takes effect at the consume after a stall.
    tbl.delete();
    tbl.push_back(v(0,0,0,           0,0,0,0,            0,0,0,0,                      0,0,0));
    tbl.push_back(v(1,0,0,           0,0,0,0,            1,32'h0,0,0,                  0,0,0));
    tbl.push_back(v(0,1,mem(32'h0),  0,1,0,0,            0,0,0,0,                      0,0,0));
    tbl.push_back(v(0,0,0,           1,0,0,0,            0,0,1,32'h0,                  0,0,0));
    tbl.push_back(v(0,0,0,           0,0,0,0,            0,0,1,32'h0,                  0,0,0));
    tbl.push_back(v(0,0,0,           0,0,1,32'h80,       0,0,0,0,                      0,0,1));
    tbl.push_back(v(1,1,mem(32'h4),  0,0,0,0,            0,0,0,0,                      0,0,1));
    tbl.push_back(v(0,0,0,           0,0,0,0,            0,0,0,0,                      0,0,1));
    tbl.push_back(v(0,0,0,           0,0,0,0,            0,0,0,0,                      0,0,1));
    do_reset();
    run_table("halt");

    // Asynchronous reset mid-HALT, then a stray response right after release.
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    imem_rvalid = 1'b1; imem_rdata = 32'hBAD0_BAD0;
    @(negedge clk);
    drive_idle();
    chk("post_rst.req", {31'b0, imem_req}, 32'd1);
    chk("post_rst.addr", imem_addr, 32'h0);
    chk("post_rst.ifv", {31'b0, if_valid}, 32'd0);
    chk("post_rst.inst", if_inst, NOP);
    @(negedge clk);
    chk("post_rst.req_held", {31'b0, imem_req}, 32'd1);
    chk("post_rst.halted", {31'b0, halted}, 32'd0);

    do_reset();
    run_random(4000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Fetch-side controller that owns the program counter and sequences instruction fetch for the multi-cycle core. It issues one instruction-memory request at a time, presents fetched instructions to decode with a valid/stall handshake, and applies control-flow redirects computed by the next-PC logic (branch and JAL/JALR targets). It discards in-flight fetches made stale by a redirect and traps misaligned targets.

## Interface
- RESET_VECTOR, 32'h0000_0000, PC of first fetch after reset
- TRAP_VECTOR, 32'h0000_0100, PC loaded on misaligned redirect
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- redirect_valid  in  1  redirect request from next-PC logic, single-cycle
- redirect_pc  in  32  redirect target
- stall  in  1  decode cannot accept the presented instruction
- halt_req  in  1  stop fetching after the current instruction is consumed
- imem_req  out  1  fetch request
- imem_addr  out  32  fetch address, word aligned
- imem_gnt  in  1  memory accepts the request this cycle
- imem_rvalid  in  1  read data valid
- imem_rdata  in  32  read data
- if_valid  out  1  instruction presented to decode
- if_pc  out  32  PC of presented instruction
- if_inst  out  32  presented instruction
- flush  out  1  one-cycle pulse: younger pipeline contents invalid
- misalign_trap  out  1  one-cycle pulse: redirect target misaligned
- halted  out  1  sequencer stopped

## Operation
- States: IDLE, REQ, WAIT, HOLD, HALT.
- IDLE: entered on reset; next cycle goes to REQ with pc = RESET_VECTOR.
- REQ: imem_req=1, imem_addr=pc. imem_addr must not change while imem_req=1 and imem_gnt=0. On imem_gnt, go to WAIT.
- WAIT: on imem_rvalid, if the kill flag is clear, register if_inst=imem_rdata, if_pc=fetch address, if_valid=1, and go to HOLD. If kill is set, clear kill, drop the data, and go to REQ.
- HOLD: if_valid=1, with if_pc and if_inst stable. When stall=0, the instruction is consumed: if_valid<=0, pc<=if_pc+4, and go to REQ, or to HALT if halt_req is pending.
- Redirect (any state except IDLE and HALT): flush pulses the next cycle.
  - redirect_pc[1:0]!=0: misalign_trap pulses with flush, and the target becomes TRAP_VECTOR.
  - IDLE: redirect ignored.
  - REQ without gnt: the request is held and pc_pending is latched. On gnt, set kill and go to WAIT.
  - REQ with gnt in the same cycle: set kill and latch the target.
  - WAIT: set kill and latch the target. The killed response is followed by REQ at the latched target.
  - HOLD: if_valid<=0 and go to REQ at the target. Redirect takes priority over stall=0.
- Multiple redirects before the killed response returns: the last one wins.
- halt_req is sticky once sampled high. It takes effect only at a consume or kill boundary. HALT is exited only by reset. Redirects in HALT are ignored.
- Arithmetic: pc+4 is modulo 2^32; 32'hFFFF_FFFC wraps to 0.
- imem_rvalid outside WAIT is ignored.

## Timing
- Reset values: imem_req=0, imem_addr=RESET_VECTOR, if_valid=0, if_pc=0, if_inst=32'h0000_0013 (NOP), flush=0, misalign_trap=0, halted=0. kill, pending and halt flags are cleared.
- Reset mid-operation clears everything immediately. A response arriving after reset release is ignored.
- Best case per instruction: REQ (gnt) -> WAIT (rvalid next cycle) -> HOLD (stall=0), then REQ at the next PC. That is 3 cycles per instruction.
- First request is asserted in the 2nd cycle after reset release.
- Redirect latency:
  - flush occurs one cycle after redirect_valid.
  - From HOLD, imem_req at the new target occurs the cycle after redirect_valid.
- halted rises the cycle HALT is entered.
- Only one outstanding fetch exists at any time.

## Structure
- Shared core package:
  - state enum (IDLE/REQ/WAIT/HOLD/HALT)
  - NOP encoding constant
  - default RESET_VECTOR/TRAP_VECTOR constants
- No sub-module. The PC register, pending and kill flags, output registers and FSM live in one module. Target selection and misalignment check are a small combinational section.

## Test plan
- Reset, gnt same cycle, rvalid +1, stall=0 -> fetch addresses 0x0, 0x4, 0x8 at 3-cycle spacing; if_pc matches each address.
- HOLD with stall=1 for 4 cycles -> if_valid, if_pc and if_inst stable for all 4 cycles; next imem_addr = if_pc+4 after stall drops.
- redirect_valid to 0x200 while in WAIT -> flush pulses; the returning rdata is never presented; next imem_addr=0x200.
- redirect_pc=0x202 in HOLD -> flush and misalign_trap pulse together; next imem_addr=TRAP_VECTOR.
- imem_gnt withheld 5 cycles while redirect to 0x40 arrives -> imem_addr unchanged until gnt; that fetch killed; next request 0x40.
- halt_req in WAIT, then rst_n low mid-HALT -> halted=1 after consume, no further imem_req; reset returns all outputs to reset values.
